// File: rtl/ppu_ri.sv
// ppu_ri - CPU-side register interface of the picture processing unit.
//
// Decodes the eight CPU-visible registers (the caller handles mirroring),
// holds PPUCTRL/PPUMASK/PPUSCROLL, the 14-bit VRAM address register with its
// shared first/second write toggle, the vblank status flag, and a small FSM
// that turns data-port accesses into one-cycle VRAM strobes.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   sel_i             register select (CPU A[2:0])
//   ncs_i             active-low chip select; one access per low period
//   r_nw_i            1 = CPU read, 0 = CPU write
//   cpu_din_i         CPU write data
//   cpu_dout_o        registered CPU read data
//   vram_a_o          VRAM address (the internal address register)
//   vram_din_i        VRAM read data, valid the cycle after vram_rd_o
//   vram_dout_o       VRAM write data
//   vram_wr_o/rd_o    one-cycle VRAM write / read strobes
//   vblank_set_i/clr_i  vblank flag pulses from the renderer timing
//   nmi_o             vblank AND nmi_en
//   nt_sel_o .. nmi_en_o  PPUCTRL fields
//   bg_en_o, spr_en_o     PPUMASK fields
//   scroll_x_o/y_o        PPUSCROLL values
module ppu_ri (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel_i,
  input  logic        ncs_i,
  input  logic        r_nw_i,
  input  logic [7:0]  cpu_din_i,
  output logic [7:0]  cpu_dout_o,
  output logic [13:0] vram_a_o,
  input  logic [7:0]  vram_din_i,
  output logic [7:0]  vram_dout_o,
  output logic        vram_wr_o,
  output logic        vram_rd_o,
  input  logic        vblank_set_i,
  input  logic        vblank_clr_i,
  output logic        nmi_o,
  output logic [1:0]  nt_sel_o,
  output logic        addr_inc_o,
  output logic        spr_pt_sel_o,
  output logic        bg_pt_sel_o,
  output logic        nmi_en_o,
  output logic        bg_en_o,
  output logic        spr_en_o,
  output logic [7:0]  scroll_x_o,
  output logic [7:0]  scroll_y_o
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FILL} state_t;

  state_t      state_q, state_d;
  logic        ncsPrev_q;
  logic [7:0]  cpuDout_q, cpuDout_d;
  logic [7:0]  vramDout_q, vramDout_d;
  logic [7:0]  buffer_q, buffer_d;
  logic [7:0]  scrollX_q, scrollX_d;
  logic [7:0]  scrollY_q, scrollY_d;
  logic [13:0] addr_q, addr_d;
  logic        toggle_q, toggle_d;
  logic        vblank_q, vblank_d;
  logic [1:0]  ntSel_q, ntSel_d;
  logic        addrInc_q, addrInc_d;
  logic        sprPt_q, sprPt_d;
  logic        bgPt_q, bgPt_d;
  logic        nmiEn_q, nmiEn_d;
  logic        bgEn_q, bgEn_d;
  logic        sprEn_q, sprEn_d;
  logic        access;
  logic        statusRead;
  logic        vramWr, vramRd;
  logic [13:0] incr;

  // An access is the falling edge of ncs seen against last cycle's value,
  // so holding ncs low for many cycles still yields a single access.
  assign access = ncsPrev_q & ~ncs_i;
  assign incr   = addrInc_q ? 14'd32 : 14'd1;

  // Next-state and strobe logic. Only IDLE looks at the access edge, which
  // is what makes an edge during WRITE/READ/FILL vanish without effect.
  always_comb begin
    state_d    = state_q;
    cpuDout_d  = cpuDout_q;
    vramDout_d = vramDout_q;
    buffer_d   = buffer_q;
    scrollX_d  = scrollX_q;
    scrollY_d  = scrollY_q;
    addr_d     = addr_q;
    toggle_d   = toggle_q;
    ntSel_d    = ntSel_q;
    addrInc_d  = addrInc_q;
    sprPt_d    = sprPt_q;
    bgPt_d     = bgPt_q;
    nmiEn_d    = nmiEn_q;
    bgEn_d     = bgEn_q;
    sprEn_d    = sprEn_q;
    statusRead = 1'b0;
    vramWr     = 1'b0;
    vramRd     = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (r_nw_i) begin
            case (sel_i)
              3'd2: begin
                cpuDout_d  = {vblank_q, 7'b0};
                toggle_d   = 1'b0;
                statusRead = 1'b1;
              end
              3'd7: begin
                // Data port reads return the previously buffered byte.
                cpuDout_d = buffer_q;
                state_d   = READ;
              end
              default: cpuDout_d = 8'h00;
            endcase
          end else begin
            case (sel_i)
              3'd0: begin
                ntSel_d   = cpu_din_i[1:0];
                addrInc_d = cpu_din_i[2];
                sprPt_d   = cpu_din_i[3];
                bgPt_d    = cpu_din_i[4];
                nmiEn_d   = cpu_din_i[7];
              end
              3'd1: begin
                bgEn_d  = cpu_din_i[3];
                sprEn_d = cpu_din_i[4];
              end
              3'd5: begin
                if (toggle_q) scrollY_d = cpu_din_i;
                else          scrollX_d = cpu_din_i;
                toggle_d = ~toggle_q;
              end
              3'd6: begin
                if (toggle_q) addr_d = {addr_q[13:8], cpu_din_i};
                else          addr_d = {cpu_din_i[5:0], addr_q[7:0]};
                toggle_d = ~toggle_q;
              end
              3'd7: begin
                vramDout_d = cpu_din_i;
                state_d    = WRITE;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        vramWr  = 1'b1;
        addr_d  = addr_q + incr;
        state_d = IDLE;
      end
      READ: begin
        vramRd  = 1'b1;
        state_d = FILL;
      end
      FILL: begin
        buffer_d = vram_din_i;
        addr_d   = addr_q + incr;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear beats set, and set beats the status-read clear, so a read that
    // races the set pulse still leaves the flag raised for the next read.
    if (vblank_clr_i)      vblank_d = 1'b0;
    else if (vblank_set_i) vblank_d = 1'b1;
    else if (statusRead)   vblank_d = 1'b0;
    else                   vblank_d = vblank_q;
  end

  // State register. The edge detector resets high so that ncs already low
  // right after reset counts as a fresh access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ncsPrev_q  <= 1'b1;
      cpuDout_q  <= 8'h00;
      vramDout_q <= 8'h00;
      buffer_q   <= 8'h00;
      scrollX_q  <= 8'h00;
      scrollY_q  <= 8'h00;
      addr_q     <= 14'h0000;
      toggle_q   <= 1'b0;
      vblank_q   <= 1'b0;
      ntSel_q    <= 2'b00;
      addrInc_q  <= 1'b0;
      sprPt_q    <= 1'b0;
      bgPt_q     <= 1'b0;
      nmiEn_q    <= 1'b0;
      bgEn_q     <= 1'b0;
      sprEn_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ncsPrev_q  <= ncs_i;
      cpuDout_q  <= cpuDout_d;
      vramDout_q <= vramDout_d;
      buffer_q   <= buffer_d;
      scrollX_q  <= scrollX_d;
      scrollY_q  <= scrollY_d;
      addr_q     <= addr_d;
      toggle_q   <= toggle_d;
      vblank_q   <= vblank_d;
      ntSel_q    <= ntSel_d;
      addrInc_q  <= addrInc_d;
      sprPt_q    <= sprPt_d;
      bgPt_q     <= bgPt_d;
      nmiEn_q    <= nmiEn_d;
      bgEn_q     <= bgEn_d;
      sprEn_q    <= sprEn_d;
    end
  end

  assign cpu_dout_o   = cpuDout_q;
  assign vram_a_o     = addr_q;
  assign vram_dout_o  = vramDout_q;
  assign vram_wr_o    = vramWr;
  assign vram_rd_o    = vramRd;
  assign nmi_o        = vblank_q & nmiEn_q;
  assign nt_sel_o     = ntSel_q;
  assign addr_inc_o   = addrInc_q;
  assign spr_pt_sel_o = sprPt_q;
  assign bg_pt_sel_o  = bgPt_q;
  assign nmi_en_o     = nmiEn_q;
  assign bg_en_o      = bgEn_q;
  assign spr_en_o     = sprEn_q;
  assign scroll_x_o   = scrollX_q;
  assign scroll_y_o   = scrollY_q;

endmodule

// File: tb/tb_ppu_ri.sv
// tb_ppu_ri - self-checking bench for ppu_ri.
//
// Drives CPU accesses as whole transactions (ncs high, one low access cycle,
// then enough idle cycles for any VRAM cycle to finish), compares against a
// fixed vector table, hand-written corner sequences, and a randomized run
// checked against a transaction-level model of the register map.
module tb_ppu_ri;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel_i;
  logic        ncs_i;
  logic        r_nw_i;
  logic [7:0]  cpu_din_i;
  logic [7:0]  cpu_dout_o;
  logic [13:0] vram_a_o;
  logic [7:0]  vram_din_i;
  logic [7:0]  vram_dout_o;
  logic        vram_wr_o;
  logic        vram_rd_o;
  logic        vblank_set_i;
  logic        vblank_clr_i;
  logic        nmi_o;
  logic [1:0]  nt_sel_o;
  logic        addr_inc_o;
  logic        spr_pt_sel_o;
  logic        bg_pt_sel_o;
  logic        nmi_en_o;
  logic        bg_en_o;
  logic        spr_en_o;
  logic [7:0]  scroll_x_o;
  logic [7:0]  scroll_y_o;

  ppu_ri dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .ncs_i(ncs_i), .r_nw_i(r_nw_i),
    .cpu_din_i(cpu_din_i), .cpu_dout_o(cpu_dout_o), .vram_a_o(vram_a_o),
    .vram_din_i(vram_din_i), .vram_dout_o(vram_dout_o),
    .vram_wr_o(vram_wr_o), .vram_rd_o(vram_rd_o),
    .vblank_set_i(vblank_set_i), .vblank_clr_i(vblank_clr_i), .nmi_o(nmi_o),
    .nt_sel_o(nt_sel_o), .addr_inc_o(addr_inc_o),
    .spr_pt_sel_o(spr_pt_sel_o), .bg_pt_sel_o(bg_pt_sel_o),
    .nmi_en_o(nmi_en_o), .bg_en_o(bg_en_o), .spr_en_o(spr_en_o),
    .scroll_x_o(scroll_x_o), .scroll_y_o(scroll_y_o)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        rnw;
    logic [7:0]  data;
    logic [7:0]  vdin;
    logic [7:0]  expDout;
    logic [13:0] expAddr;
    int          expWr;
    int          expRd;
    logic [13:0] expWrA;
    logic [7:0]  expWrD;
  } vec_t;

  vec_t vecs [21];

  int compared = 0;
  int mismatched = 0;

  int          wrCount;
  int          rdCount;
  logic        bothSeen;
  logic [13:0] wrAddr;
  logic [7:0]  wrData;

  // transaction-level model state
  logic [7:0]  mCtrl, mMask, mSx, mSy, mBuf, mDout;
  int          mAddr;
  logic        mToggle, mVblank;

  // Advance one clock and land 1 ns past the edge, where outputs are stable.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete CPU access followed by four observation cycles.
  task automatic applyStimulus(input logic [2:0] s, input logic rnw,
                               input logic [7:0] d, input logic [7:0] vdin,
                               input logic setDuring);
    ncs_i = 1'b1;
    cycle();
    sel_i = s; r_nw_i = rnw; cpu_din_i = d; vram_din_i = vdin;
    vblank_set_i = setDuring;
    ncs_i = 1'b0;
    cycle();
    ncs_i = 1'b1;
    vblank_set_i = 1'b0;
    wrCount = 0; rdCount = 0; bothSeen = 1'b0;
    wrAddr = '0; wrData = '0;
    for (int i = 0; i < 4; i++) begin
      if (vram_wr_o) begin
        wrCount++;
        wrAddr = vram_a_o;
        wrData = vram_dout_o;
      end
      if (vram_rd_o) rdCount++;
      if (vram_wr_o && vram_rd_o) bothSeen = 1'b1;
      cycle();
    end
  endtask

  task automatic pulseVblank(input logic s, input logic c);
    vblank_set_i = s;
    vblank_clr_i = c;
    cycle();
    vblank_set_i = 1'b0;
    vblank_clr_i = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    ncs_i = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  task automatic modelReset();
    mCtrl = 0; mMask = 0; mSx = 0; mSy = 0; mBuf = 0; mDout = 0;
    mAddr = 0; mToggle = 0; mVblank = 0;
  endtask

  // Reference behaviour of one access, phrased as register-map rules.
  task automatic modelAccess(input logic [2:0] s, input logic rnw,
                             input logic [7:0] d, input logic [7:0] vdin,
                             input logic setDuring, output int eWr,
                             output int eRd, output int eWrA);
    int inc;
    inc = mCtrl[2] ? 32 : 1;
    eWr = 0; eRd = 0; eWrA = 0;
    if (rnw) begin
      if (s == 3'd2) begin
        mDout = mVblank ? 8'h80 : 8'h00;
        mVblank = setDuring;
        mToggle = 1'b0;
      end else if (s == 3'd7) begin
        mDout = mBuf;
        mBuf = vdin;
        mAddr = (mAddr + inc) % 16384;
        eRd = 1;
        if (setDuring) mVblank = 1'b1;
      end else begin
        mDout = 8'h00;
        if (setDuring) mVblank = 1'b1;
      end
    end else begin
      if (setDuring) mVblank = 1'b1;
      case (s)
        3'd0: mCtrl = d;
        3'd1: mMask = d;
        3'd5: begin
          if (mToggle) mSy = d; else mSx = d;
          mToggle = ~mToggle;
        end
        3'd6: begin
          if (mToggle) mAddr = (mAddr / 256) * 256 + d;
          else         mAddr = (d % 64) * 256 + (mAddr % 256);
          mToggle = ~mToggle;
        end
        3'd7: begin
          eWr = 1;
          eWrA = mAddr;
          mAddr = (mAddr + inc) % 16384;
        end
        default: ;
      endcase
    end
  endtask

  task automatic resetMid(input logic rnw, input int extraCycles);
    ncs_i = 1'b1;
    cycle();
    sel_i = 3'd7; r_nw_i = rnw; cpu_din_i = 8'h5C; vram_din_i = 8'hE7;
    ncs_i = 1'b0;
    cycle();
    ncs_i = 1'b1;
    repeat (extraCycles) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("abortWr", vram_wr_o, 0);
    checkOutput("abortRd", vram_rd_o, 0);
    checkOutput("abortAddr", vram_a_o, 0);
    cycle();
    checkOutput("abortAddrLater", vram_a_o, 0);
  endtask

  initial begin
    int eWr, eRd, eWrA;
    logic [2:0] s;
    logic rnw, sd;
    logic [7:0] d, vd;
    int r;

    rst = 1'b1; sel_i = 0; ncs_i = 1'b1; r_nw_i = 1'b1; cpu_din_i = 0;
    vram_din_i = 0; vblank_set_i = 0; vblank_clr_i = 0;

    vecs[0]  = '{3'd6, 1'b0, 8'h21, 8'h00, 8'h00, 14'h2100, 0, 0, 14'h0000, 8'h00};
    vecs[1]  = '{3'd6, 1'b0, 8'h08, 8'h00, 8'h00, 14'h2108, 0, 0, 14'h0000, 8'h00};
    vecs[2]  = '{3'd7, 1'b0, 8'hAB, 8'h00, 8'h00, 14'h2109, 1, 0, 14'h2108, 8'hAB};
    vecs[3]  = '{3'd0, 1'b0, 8'h04, 8'h00, 8'h00, 14'h2109, 0, 0, 14'h0000, 8'h00};
    vecs[4]  = '{3'd6, 1'b0, 8'h20, 8'h00, 8'h00, 14'h2009, 0, 0, 14'h0000, 8'h00};
    vecs[5]  = '{3'd6, 1'b0, 8'h00, 8'h00, 8'h00, 14'h2000, 0, 0, 14'h0000, 8'h00};
    vecs[6]  = '{3'd7, 1'b1, 8'h00, 8'h11, 8'h00, 14'h2020, 0, 1, 14'h0000, 8'h00};
    vecs[7]  = '{3'd7, 1'b1, 8'h00, 8'h22, 8'h11, 14'h2040, 0, 1, 14'h0000, 8'h00};
    vecs[8]  = '{3'd0, 1'b0, 8'h00, 8'h00, 8'h11, 14'h2040, 0, 0, 14'h0000, 8'h00};
    vecs[9]  = '{3'd6, 1'b0, 8'h3F, 8'h00, 8'h11, 14'h3F40, 0, 0, 14'h0000, 8'h00};
    vecs[10] = '{3'd6, 1'b0, 8'hFF, 8'h00, 8'h11, 14'h3FFF, 0, 0, 14'h0000, 8'h00};
    vecs[11] = '{3'd7, 1'b0, 8'h5A, 8'h00, 8'h11, 14'h0000, 1, 0, 14'h3FFF, 8'h5A};
    vecs[12] = '{3'd6, 1'b0, 8'h3F, 8'h00, 8'h11, 14'h3F00, 0, 0, 14'h0000, 8'h00};
    vecs[13] = '{3'd2, 1'b1, 8'h00, 8'h00, 8'h00, 14'h3F00, 0, 0, 14'h0000, 8'h00};
    vecs[14] = '{3'd6, 1'b0, 8'h20, 8'h00, 8'h00, 14'h2000, 0, 0, 14'h0000, 8'h00};
    vecs[15] = '{3'd6, 1'b0, 8'h00, 8'h00, 8'h00, 14'h2000, 0, 0, 14'h0000, 8'h00};
    vecs[16] = '{3'd7, 1'b1, 8'h00, 8'h77, 8'h22, 14'h2001, 0, 1, 14'h0000, 8'h00};
    vecs[17] = '{3'd3, 1'b1, 8'h00, 8'h00, 8'h00, 14'h2001, 0, 0, 14'h0000, 8'h00};
    vecs[18] = '{3'd7, 1'b1, 8'h00, 8'h00, 8'h77, 14'h2002, 0, 1, 14'h0000, 8'h00};
    vecs[19] = '{3'd3, 1'b0, 8'hFF, 8'h00, 8'h77, 14'h2002, 0, 0, 14'h0000, 8'h00};
    vecs[20] = '{3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 14'h2002, 0, 0, 14'h0000, 8'h00};

    // reset state
    doReset();
    checkOutput("rstDout", cpu_dout_o, 0);
    checkOutput("rstAddr", vram_a_o, 0);
    checkOutput("rstVdout", vram_dout_o, 0);
    checkOutput("rstStrobes", {vram_wr_o, vram_rd_o, nmi_o}, 0);
    checkOutput("rstCtrl", {nt_sel_o, addr_inc_o, spr_pt_sel_o, bg_pt_sel_o,
                            nmi_en_o, bg_en_o, spr_en_o}, 0);
    checkOutput("rstScroll", {scroll_x_o, scroll_y_o}, 0);

    // vector table
    $display("[TB] vector table");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].rnw, vecs[i].data, vecs[i].vdin, 1'b0);
      checkOutput($sformatf("vec%0d.dout", i), cpu_dout_o, vecs[i].expDout);
      checkOutput($sformatf("vec%0d.addr", i), vram_a_o, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d.wr", i), wrCount, vecs[i].expWr);
      checkOutput($sformatf("vec%0d.rd", i), rdCount, vecs[i].expRd);
      checkOutput($sformatf("vec%0d.overlap", i), bothSeen, 0);
      if (vecs[i].expWr == 1) begin
        checkOutput($sformatf("vec%0d.wrA", i), wrAddr, vecs[i].expWrA);
        checkOutput($sformatf("vec%0d.wrD", i), wrData, vecs[i].expWrD);
      end
    end

    // vblank / nmi interplay
    $display("[TB] vblank and nmi");
    applyStimulus(3'd0, 1'b0, 8'h80, 8'h00, 1'b0);
    checkOutput("nmiEn", nmi_en_o, 1);
    checkOutput("nmiIdle", nmi_o, 0);
    pulseVblank(1'b1, 1'b0);
    checkOutput("nmiSet", nmi_o, 1);
    applyStimulus(3'd2, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("statusDout", cpu_dout_o, 8'h80);
    checkOutput("nmiAfterRead", nmi_o, 0);
    applyStimulus(3'd2, 1'b1, 8'h00, 8'h00, 1'b1);
    checkOutput("raceDout", cpu_dout_o, 8'h00);
    checkOutput("raceNmi", nmi_o, 1);
    pulseVblank(1'b1, 1'b1);
    checkOutput("clrWins", nmi_o, 0);

    // ncs held low for ten cycles: exactly one write
    $display("[TB] long chip select");
    ncs_i = 1'b1;
    cycle();
    sel_i = 3'd7; r_nw_i = 1'b0; cpu_din_i = 8'hC3; ncs_i = 1'b0;
    wrCount = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (vram_wr_o) wrCount++;
    end
    ncs_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (vram_wr_o) wrCount++;
    end
    checkOutput("longNcsWr", wrCount, 1);
    checkOutput("longNcsAddr", vram_a_o, 14'h2003);

    // second access edge while the read is still in flight
    $display("[TB] edge while busy");
    ncs_i = 1'b1;
    cycle();
    sel_i = 3'd7; r_nw_i = 1'b1; vram_din_i = 8'h9C; ncs_i = 1'b0;
    cycle();
    ncs_i = 1'b1;
    cycle();
    sel_i = 3'd6; r_nw_i = 1'b0; cpu_din_i = 8'h12; ncs_i = 1'b0;
    cycle();
    ncs_i = 1'b1;
    repeat (3) cycle();
    checkOutput("busyAddr", vram_a_o, 14'h2004);
    checkOutput("busyDout", cpu_dout_o, 8'h00);
    applyStimulus(3'd6, 1'b0, 8'h3F, 8'h00, 1'b0);
    applyStimulus(3'd6, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("busyToggle", vram_a_o, 14'h3F00);
    applyStimulus(3'd7, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("busyBuffer", cpu_dout_o, 8'h9C);

    // reset in the middle of VRAM cycles
    $display("[TB] reset mid-cycle");
    resetMid(1'b0, 0);
    applyStimulus(3'd6, 1'b0, 8'h15, 8'h00, 1'b0);
    resetMid(1'b1, 0);
    applyStimulus(3'd6, 1'b0, 8'h15, 8'h00, 1'b0);
    resetMid(1'b1, 1);
    applyStimulus(3'd7, 1'b1, 8'h00, 8'h44, 1'b0);
    checkOutput("abortBuffer", cpu_dout_o, 8'h00);

    // randomized run against the model
    $display("[TB] random run");
    doReset();
    modelReset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin pulseVblank(1'b1, 1'b0); mVblank = 1'b1; end
      else if (r == 1) begin pulseVblank(1'b0, 1'b1); mVblank = 1'b0; end
      else if (r == 2) begin pulseVblank(1'b1, 1'b1); mVblank = 1'b0; end
      s   = 3'($urandom_range(0, 7));
      rnw = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      vd  = 8'($urandom);
      sd  = ($urandom_range(0, 15) == 0);
      modelAccess(s, rnw, d, vd, sd, eWr, eRd, eWrA);
      applyStimulus(s, rnw, d, vd, sd);
      checkOutput($sformatf("rnd%0d.dout", n), cpu_dout_o, mDout);
      checkOutput($sformatf("rnd%0d.addr", n), vram_a_o, mAddr);
      checkOutput($sformatf("rnd%0d.wr", n), wrCount, eWr);
      checkOutput($sformatf("rnd%0d.rd", n), rdCount, eRd);
      checkOutput($sformatf("rnd%0d.nmi", n), nmi_o, mVblank & mCtrl[7]);
      checkOutput($sformatf("rnd%0d.ctrl", n),
                  {nmi_en_o, bg_pt_sel_o, spr_pt_sel_o, addr_inc_o, nt_sel_o},
                  {mCtrl[7], mCtrl[4], mCtrl[3], mCtrl[2], mCtrl[1:0]});
      checkOutput($sformatf("rnd%0d.mask", n), {bg_en_o, spr_en_o},
                  {mMask[3], mMask[4]});
      checkOutput($sformatf("rnd%0d.scroll", n), {scroll_x_o, scroll_y_o},
                  {mSx, mSy});
      if (eWr == 1) begin
        checkOutput($sformatf("rnd%0d.wrA", n), wrAddr, eWrA);
        checkOutput($sformatf("rnd%0d.wrD", n), wrData, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ppu_ri.md
PPU_RI -- requirements
Module: ppu_ri

Interface
REQ-001 Parameters: none; fixed 8-register PPU CPU-side map ($2000-$2007, mirrored by caller).
REQ-002 clk  in  1  50MHz system clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 sel  in  3  register select (CPU A[2:0]).
REQ-005 ncs  in  1  chip select, active-low; may stay low for many clk cycles.
REQ-006 r_nw  in  1  1=CPU read, 0=CPU write; sampled with sel/cpu_din in access cycle.
REQ-007 cpu_din  in  8  CPU write data.
REQ-008 cpu_dout  out  8  CPU read data, registered.
REQ-009 vram_a  out  14  VRAM address; equals internal address register at all times.
REQ-010 vram_din  in  8  VRAM read data, valid the cycle after vram_rd.
REQ-011 vram_dout  out  8  VRAM write data.
REQ-012 vram_wr / vram_rd  out  1 each  one-cycle write / read strobes.
REQ-013 vblank_set, vblank_clr  in  1 each  single-cycle pulses from renderer timing.
REQ-014 nmi  out  1  active-high level = vblank AND nmi_en.
REQ-015 nt_sel[1:0], addr_inc, spr_pt_sel, bg_pt_sel, nmi_en  out  PPUCTRL fields.
REQ-016 bg_en, spr_en  out  1 each  PPUMASK fields.
REQ-017 scroll_x, scroll_y  out  8 each  PPUSCROLL values.

Function
REQ-018 Access = first cycle with ncs low after a cycle with ncs high (registered ncs edge detect); one access per low period.
REQ-019 Write sel0: nt_sel=d[1:0], addr_inc=d[2], spr_pt_sel=d[3], bg_pt_sel=d[4], nmi_en=d[7]; visible next cycle.
REQ-020 Write sel1: bg_en=d[3], spr_en=d[4].
REQ-021 Read sel2: cpu_dout={vblank,7'b0} using pre-clear value; then vblank=0, toggle=0.
REQ-022 Write sel5: toggle 0 -> scroll_x=d; toggle 1 -> scroll_y=d; toggle flips.
REQ-023 Write sel6: toggle 0 -> addr[13:8]=d[5:0]; toggle 1 -> addr[7:0]=d; toggle flips.
REQ-024 Writes to sel 0,1,5,6,7 and reads of 2,7 defined; all other accesses: no state change, read returns 8'h00.
REQ-025 FSM states IDLE, WRITE, READ, FILL; only IDLE accepts accesses.
REQ-026 Write sel7 in IDLE: latch d into vram_dout, -> WRITE; WRITE: vram_wr=1 one cycle, addr+=inc, -> IDLE.
REQ-027 Read sel7 in IDLE: cpu_dout=read buffer (old value), -> READ; READ: vram_rd=1; -> FILL; FILL: buffer=vram_din, addr+=inc, -> IDLE.
REQ-028 inc = 1 if addr_inc=0, else 32; addr 14-bit, wraps 14'h3FFF -> 14'h0000 (or 14'h3FE0+32 -> 14'h0000).
REQ-029 Access edge arriving while FSM not IDLE: ignored entirely (no register, toggle, or output change).
REQ-030 vblank: set by vblank_set; cleared by vblank_clr or sel2 read; set and sel2 read same cycle -> read returns 0, flag ends 1; set and clr same cycle -> clr wins.
REQ-031 cpu_dout holds its value until next read access; writes never change it.
REQ-032 vram_wr and vram_rd never asserted together; each high at most one cycle per access.

Reset
REQ-033 rst forces: all control/scroll outputs, addr, toggle, vblank, buffer, cpu_dout, vram_dout = 0; vram_wr=vram_rd=0; FSM=IDLE; ncs edge register=1 (no access fires on first post-reset cycle with ncs low? fires, treated as new edge).
REQ-034 rst mid-WRITE/READ/FILL aborts: no strobe in following cycle, addr not incremented, buffer unchanged (0).

Verification
REQ-035 Write sel6 8'h21, 8'h08; write sel7 8'hAB -> vram_wr one cycle at vram_a=14'h2108, vram_dout=8'hAB; vram_a then 14'h2109.
REQ-036 sel0=8'h04, addr=14'h2000, two sel7 reads with vram_din=8'h11 then 8'h22 -> cpu_dout 8'h00 then 8'h11; addr 14'h2040.
REQ-037 addr=14'h3FFF, addr_inc=0, sel7 write -> vram_a wraps to 14'h0000.
REQ-038 One sel6 write 8'h3F, sel2 read, sel6 writes 8'h20, 8'h00 -> addr 14'h2000 (toggle reset by status read).
REQ-039 nmi_en=1, vblank_set pulse -> nmi=1; sel2 read returns 8'h80, nmi=0 next cycle; vblank_set coincident with sel2 read -> cpu_dout 8'h00, nmi=1.
REQ-040 Hold ncs low 10 cycles on sel7 write -> exactly one vram_wr; second ncs edge during READ -> ignored, addr advances once.
